// File: rtl/cache_data_mem_banked.sv
// ---------------------------------------------------------------------------
// cache_data_mem_banked
//
// Banked pixel-line store sitting under the inter-prediction cache controller.
// 2^LG_BANKS banks, each holding 2^LINE_ADDR_WDTH lines of SAMPLES_PER_LINE
// samples. One masked write port, one read port. After reset a hardware
// sweep zeroes every line. Requests are ignored while the sweep runs.
//
// Ports
//   clk            clock
//   reset_n        synchronous active-low reset
//   init_busy_out  1 while the zeroing sweep runs
//   wr_en_in       write request
//   wr_bank_in     write bank
//   wr_addr_in     write line address
//   wr_smp_en_in   per-sample write enable (bit i -> sample i)
//   wr_data_in     write line; sample i = bits [i*BIT_DEPTH +: BIT_DEPTH]
//   rd_en_in       read request
//   rd_bank_in     read bank
//   rd_addr_in     read line address
//   rd_data_out    read line (holds its value between reads)
//   rd_valid_out   one-cycle pulse, rd_data_out carries a requested line
// ---------------------------------------------------------------------------
module cache_data_mem_banked #(
    parameter int BIT_DEPTH        = 8,
    parameter int SAMPLES_PER_LINE = 48,
    parameter int LG_BANKS         = 2,
    parameter int LINE_ADDR_WDTH   = 5,
    parameter int OUT_REG          = 0,
    parameter int WR_FWD           = 1
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    output logic                                    init_busy_out,
    input  logic                                    wr_en_in,
    input  logic [LG_BANKS-1:0]                     wr_bank_in,
    input  logic [LINE_ADDR_WDTH-1:0]               wr_addr_in,
    input  logic [SAMPLES_PER_LINE-1:0]             wr_smp_en_in,
    input  logic [BIT_DEPTH*SAMPLES_PER_LINE-1:0]   wr_data_in,
    input  logic                                    rd_en_in,
    input  logic [LG_BANKS-1:0]                     rd_bank_in,
    input  logic [LINE_ADDR_WDTH-1:0]               rd_addr_in,
    output logic [BIT_DEPTH*SAMPLES_PER_LINE-1:0]   rd_data_out,
    output logic                                    rd_valid_out
);

    localparam int LINE_W = BIT_DEPTH * SAMPLES_PER_LINE;
    localparam int NB     = 1 << LG_BANKS;
    localparam int DEPTH  = 1 << LINE_ADDR_WDTH;
    localparam logic [LINE_ADDR_WDTH-1:0] LAST_LINE = {LINE_ADDR_WDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Per-sample merge: enabled samples come from the new line, the rest
    // keep the old line.
    function automatic logic [LINE_W-1:0] merge_line(
        input logic [LINE_W-1:0]           old_line,
        input logic [LINE_W-1:0]           new_line,
        input logic [SAMPLES_PER_LINE-1:0] smp_en
    );
        logic [LINE_W-1:0] res;
        res = old_line;
        for (int i = 0; i < SAMPLES_PER_LINE; i++) begin
            if (smp_en[i]) begin
                res[i*BIT_DEPTH +: BIT_DEPTH] = new_line[i*BIT_DEPTH +: BIT_DEPTH];
            end else begin
                res[i*BIT_DEPTH +: BIT_DEPTH] = old_line[i*BIT_DEPTH +: BIT_DEPTH];
            end
        end
        return res;
    endfunction

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [LINE_ADDR_WDTH-1:0] init_ptr_r;
    logic [LINE_ADDR_WDTH-1:0] init_ptr_nxt_s;
    logic                      init_we_s;
    logic                      wr_go_s;
    logic                      rd_go_s;
    logic                      collide_s;
    logic [LINE_W-1:0]         bank_rd_line_s [NB];
    logic [LINE_W-1:0]         rd_old_s;
    logic [LINE_W-1:0]         rd_line_s;

    // State register and sweep pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_INIT;
            init_ptr_r <= {LINE_ADDR_WDTH{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            init_ptr_r <= init_ptr_nxt_s;
        end
    end

    // Next state and port qualification: requests only act in READY.
    always_comb begin
        state_nxt_s    = state_r;
        init_ptr_nxt_s = init_ptr_r;
        init_we_s      = 1'b0;
        wr_go_s        = 1'b0;
        rd_go_s        = 1'b0;
        case (state_r)
            ST_INIT: begin
                init_we_s      = 1'b1;
                init_ptr_nxt_s = init_ptr_r + LINE_ADDR_WDTH'(1);
                // Leave on the edge that clears the last line.
                if (init_ptr_r == LAST_LINE) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_READY: begin
                state_nxt_s = ST_READY;
                wr_go_s     = wr_en_in;
                rd_go_s     = rd_en_in;
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // state_r is itself a flop, so this output is register-driven.
    assign init_busy_out = (state_r == ST_INIT);

    // One storage array per bank; the sweep clears the same line in all banks.
    for (genvar b = 0; b < NB; b++) begin : g_bank
        localparam logic [LG_BANKS-1:0] BANK_ID = LG_BANKS'(b);
        logic [LINE_W-1:0] mem_r [DEPTH];
        logic              bank_wr_s;

        assign bank_wr_s         = wr_go_s && (wr_bank_in == BANK_ID);
        assign bank_rd_line_s[b] = mem_r[rd_addr_in];

        // Line storage: zeroing sweep or masked sample write.
        always_ff @(posedge clk) begin
            if (reset_n && init_we_s) begin
                mem_r[init_ptr_r] <= {LINE_W{1'b0}};
            end else if (reset_n && bank_wr_s) begin
                mem_r[wr_addr_in] <= merge_line(mem_r[wr_addr_in], wr_data_in, wr_smp_en_in);
            end
        end
    end

    assign rd_old_s  = bank_rd_line_s[rd_bank_in];
    assign collide_s = wr_go_s && rd_go_s &&
                       (wr_bank_in == rd_bank_in) && (wr_addr_in == rd_addr_in);

    // Read line selection: pre-write contents, or the merged line when
    // forwarding is enabled and the write hits the line being read.
    always_comb begin
        rd_line_s = rd_old_s;
        if ((WR_FWD != 0) && collide_s) begin
            rd_line_s = merge_line(rd_old_s, wr_data_in, wr_smp_en_in);
        end else begin
            rd_line_s = rd_old_s;
        end
    end

    if (OUT_REG == 0) begin : g_out_direct
        // Single read stage: data captured on the request edge.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rd_valid_out <= 1'b0;
                rd_data_out  <= {LINE_W{1'b0}};
            end else begin
                rd_valid_out <= rd_go_s;
                if (rd_go_s) begin
                    rd_data_out <= rd_line_s;
                end
            end
        end
    end else begin : g_out_reg
        logic              rd_vld1_r;
        logic [LINE_W-1:0] rd_dat1_r;

        // First read stage: capture the line on the request edge.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rd_vld1_r <= 1'b0;
                rd_dat1_r <= {LINE_W{1'b0}};
            end else begin
                rd_vld1_r <= rd_go_s;
                if (rd_go_s) begin
                    rd_dat1_r <= rd_line_s;
                end
            end
        end

        // Output stage: one extra cycle of latency, holds between reads.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rd_valid_out <= 1'b0;
                rd_data_out  <= {LINE_W{1'b0}};
            end else begin
                rd_valid_out <= rd_vld1_r;
                if (rd_vld1_r) begin
                    rd_data_out <= rd_dat1_r;
                end
            end
        end
    end

endmodule
